// File: rtl/ahbl_master_bridge.sv
// ahbl_master_bridge: AHB-lite initiator driven by a valid/ready request port.
// Requests are normalised (size clamp, address alignment) and queued in a
// 2^L2FD-entry command FIFO. The FIFO head feeds a two-stage address-phase /
// data-phase pipeline, so the address of transfer N+1 overlaps the data phase
// of transfer N. An idle pipeline takes the incoming request straight into
// the address phase, which gives NONSEQ on the bus one cycle after accept.
// Read data comes back in order on a one-cycle rsp_valid strobe.
//
// Optional build macro AHBL_MST_STATS_EN: adds the xfer_count / wait_count
// statistics counters. Without it both outputs are tied to zero.
module ahbl_master_bridge #(
    parameter int L2FD = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clken,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [31:0] ahbl_addr,
    output logic [1:0]  ahbl_trans,
    output logic        ahbl_write,
    output logic [2:0]  ahbl_size,
    output logic [31:0] ahbl_wdata,
    input  logic [31:0] ahbl_rdata,
    input  logic        ahbl_ready,
    output logic [15:0] xfer_count,
    output logic [15:0] wait_count
);

    localparam int DEPTH = 1 << L2FD;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // Pipeline occupancy, encoded as {AP valid, DP valid}.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ADDR      = 2'b10,
        ST_ADDR_DATA = 2'b11,
        ST_DATA      = 2'b01
    } state_t;

    // Clamp oversize requests to a word and align the address to the size.
    function automatic cmd_t normalise(input logic w, input logic [2:0] s,
                                       input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.write = w;
        c.size  = (s > 3'd2) ? 3'd2 : s;
        c.addr  = a;
        c.wdata = d;
        case (c.size)
            3'd1:    c.addr[0]   = 1'b0;
            3'd2:    c.addr[1:0] = 2'b00;
            default: ;
        endcase
        return c;
    endfunction

    cmd_t          fifo_mem [DEPTH];
    logic [L2FD:0] wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    cmd_t          req_cmd, head;
    logic          push, pop, bypass, load_ap, fifo_wr, advance;

    state_t        state;
    logic          ap_valid, dp_valid;
    logic [31:0]   ap_wdata;
    logic          dp_write;

    assign req_cmd    = normalise(req_write, req_size, req_addr, req_wdata);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[L2FD] != rd_ptr[L2FD]) &&
                        (wr_ptr[L2FD-1:0] == rd_ptr[L2FD-1:0]);
    assign req_ready  = ~fifo_full & clken;
    assign push       = req_valid & req_ready;

    assign ap_valid   = (state == ST_ADDR) || (state == ST_ADDR_DATA);
    assign dp_valid   = (state == ST_ADDR_DATA) || (state == ST_DATA);

    // HREADY only matters while a data phase is outstanding.
    assign advance    = clken & (~dp_valid | ahbl_ready);
    assign bypass     = advance & fifo_empty & push;
    assign pop        = advance & ~fifo_empty;
    assign load_ap    = pop | bypass;
    assign fifo_wr    = push & ~bypass;
    assign head       = fifo_empty ? req_cmd : fifo_mem[rd_ptr[L2FD-1:0]];

    // Command FIFO: write on push unless the request goes straight to AP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (fifo_wr) begin
                fifo_mem[wr_ptr[L2FD-1:0]] <= req_cmd;
                wr_ptr                     <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Pipeline FSM with registered bus outputs and read-response strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ahbl_trans <= HTRANS_IDLE;
            ahbl_addr  <= '0;
            ahbl_write <= 1'b0;
            ahbl_size  <= '0;
            ahbl_wdata <= '0;
            ap_wdata   <= '0;
            dp_write   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else if (clken) begin
            rsp_valid <= 1'b0;
            if (dp_valid && !dp_write && ahbl_ready) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= ahbl_rdata;
            end
            if (advance) begin
                // AP moves into DP; write data is presented for its data phase.
                dp_write <= ahbl_write;
                if (ap_valid && ahbl_write) ahbl_wdata <= ap_wdata;
                // Refill AP from the FIFO head (or the bypassed request).
                if (load_ap) begin
                    ahbl_trans <= HTRANS_NONSEQ;
                    ahbl_addr  <= head.addr;
                    ahbl_write <= head.write;
                    ahbl_size  <= head.size;
                    ap_wdata   <= head.wdata;
                end else begin
                    ahbl_trans <= HTRANS_IDLE;
                end
                case ({load_ap, ap_valid})
                    2'b10:   state <= ST_ADDR;
                    2'b11:   state <= ST_ADDR_DATA;
                    2'b01:   state <= ST_DATA;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef AHBL_MST_STATS_EN
    logic [15:0] xfer_q, wait_q;

    // Count completed data phases and stalled data-phase cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_q <= '0;
            wait_q <= '0;
        end else if (clken && dp_valid) begin
            if (ahbl_ready) xfer_q <= xfer_q + 16'd1;
            else            wait_q <= wait_q + 16'd1;
        end
    end

    assign xfer_count = xfer_q;
    assign wait_count = wait_q;
`else
    assign xfer_count = 16'd0;
    assign wait_count = 16'd0;
`endif

endmodule

// File: tb/tb_ahbl_master_bridge.sv
// Bench for ahbl_master_bridge: behavioural AHB-lite SRAM slave (word=address
// pattern), byte-level reference memory and in-order scoreboard.
module tb_ahbl_master_bridge;

    logic        clk = 1'b0;
    logic        reset_n, clken, req_valid, req_ready, req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata, ahbl_addr, ahbl_wdata, ahbl_rdata;
    logic [1:0]  ahbl_trans;
    logic        ahbl_write, ahbl_ready;
    logic [2:0]  ahbl_size;
    logic [15:0] xfer_count, wait_count;

    always #5 clk = ~clk;

    ahbl_master_bridge #(.L2FD(1)) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ahbl_addr(ahbl_addr), .ahbl_trans(ahbl_trans), .ahbl_write(ahbl_write),
        .ahbl_size(ahbl_size), .ahbl_wdata(ahbl_wdata), .ahbl_rdata(ahbl_rdata),
        .ahbl_ready(ahbl_ready), .xfer_count(xfer_count), .wait_count(wait_count)
    );

    typedef struct { logic w; logic [2:0] size; logic [31:0] addr; logic [31:0] wdata; } treq_t;
    typedef struct { logic w; logic [2:0] size; logic [31:0] addr; } tap_t;

    int          total = 0, bad = 0;
    logic        rnd_wait = 1'b0;
    treq_t       acc_q[$];
    tap_t        got_ap[$];
    logic [31:0] got_rsp[$];
    logic [7:0]  mbyte [256];     // reference memory, byte granular
    logic [31:0] smem [64];       // slave memory, word granular
    logic        s_dp_valid, s_dp_write;
    logic [31:0] s_dp_addr;
    logic [2:0]  s_dp_size;
    int          n_xfer, n_wait;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AHB-lite SRAM slave; the address phase is taken whenever no data phase stalls.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_dp_valid <= 1'b0;
            ahbl_rdata <= '0;
            n_xfer = 0;
            n_wait = 0;
        end else if (clken) begin
            if (s_dp_valid && ahbl_ready) begin
                n_xfer++;
                if (s_dp_write)
                    for (int b = 0; b < 4; b++)
                        if (b >= int'(s_dp_addr[1:0]) && b < int'(s_dp_addr[1:0]) + (1 << s_dp_size))
                            smem[s_dp_addr[7:2]][8*b +: 8] = ahbl_wdata[8*b +: 8];
            end
            if (s_dp_valid && !ahbl_ready) n_wait++;
            if (!s_dp_valid || ahbl_ready) begin
                s_dp_valid <= (ahbl_trans == 2'b10);
                if (ahbl_trans == 2'b10) begin
                    s_dp_write <= ahbl_write;
                    s_dp_addr  <= ahbl_addr;
                    s_dp_size  <= ahbl_size;
                    ahbl_rdata <= smem[ahbl_addr[7:2]];
                    got_ap.push_back('{ahbl_write, ahbl_size, ahbl_addr});
                end
            end
        end
    end

    // Record accepted requests and read responses.
    always @(posedge clk) begin
        if (reset_n && req_valid && req_ready)
            acc_q.push_back('{req_write, req_size, req_addr, req_wdata});
        if (reset_n && clken && rsp_valid) got_rsp.push_back(rsp_rdata);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rnd_wait) ahbl_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        logic acc = 1'b0;
        req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            #1 acc = req_ready;
            tick();
        end
        req_valid = 1'b0;
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300; i++) begin
            if (got_ap.size() == acc_q.size() && !s_dp_valid && ahbl_trans == 2'b00) break;
            tick();
        end
        chk("drain_done", (i < 300), 1'b1);
        tick(); tick();
    endtask

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0] & 8'hFC;
        return {mbyte[b + 8'd3], mbyte[b + 8'd2], mbyte[b + 8'd1], mbyte[b]};
    endfunction

    // Replay accepted requests in order against the reference memory.
    task automatic scoreboard(input string tag);
        logic [31:0] exp_rsp[$];
        chk({tag, "_nbus"}, got_ap.size(), acc_q.size());
        foreach (acc_q[i]) begin
            int unsigned sz = (acc_q[i].size > 3'd2) ? 2 : int'(acc_q[i].size);
            logic [31:0] a = acc_q[i].addr - (acc_q[i].addr % (32'd1 << sz));
            if (i < got_ap.size()) begin
                chk({tag, "_addr"},  got_ap[i].addr, a);
                chk({tag, "_size"},  got_ap[i].size, sz);
                chk({tag, "_write"}, got_ap[i].w, acc_q[i].w);
            end
            if (acc_q[i].w) begin
                for (int k = 0; k < (1 << sz); k++) begin
                    logic [7:0] ba = a[7:0] + 8'(k);
                    mbyte[ba] = acc_q[i].wdata[8*ba[1:0] +: 8];
                end
            end else exp_rsp.push_back(mword(a));
        end
        chk({tag, "_nrsp"}, got_rsp.size(), exp_rsp.size());
        foreach (exp_rsp[i]) if (i < got_rsp.size()) chk({tag, "_rdata"}, got_rsp[i], exp_rsp[i]);
        acc_q.delete(); got_ap.delete(); got_rsp.delete();
    endtask

    function automatic logic [159:0] snap_all();
        return 160'({rsp_valid, rsp_rdata, ahbl_addr, ahbl_trans, ahbl_write, ahbl_size,
                     ahbl_wdata, xfer_count, wait_count});
    endfunction

    function automatic logic [159:0] snap_bus();
        return 160'({ahbl_addr, ahbl_trans, ahbl_write, ahbl_size, ahbl_wdata});
    endfunction

    initial begin
        logic [159:0] s;
        logic [15:0]  w0;
        int           cnt, nrsp, nbusy;
        for (int a = 0; a < 256; a++) mbyte[a] = (a % 4 == 0) ? 8'(a) : 8'h00;
        for (int i = 0; i < 64; i++) smem[i] = 32'(i * 4);
        reset_n = 1'b0; clken = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = '0; req_addr = '0; req_wdata = '0; ahbl_ready = 1'b1;
        tick(); tick();

        // Reset values
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_trans",     ahbl_trans, 2'b00);
        chk("rst_addr",      ahbl_addr, 32'h0);
        chk("rst_write",     ahbl_write, 1'b0);
        chk("rst_size",      ahbl_size, 3'd0);
        chk("rst_wdata",     ahbl_wdata, 32'h0);
        chk("rst_counters",  {xfer_count, wait_count}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Zero-wait streaming reads: NONSEQ on the bus one cycle after each accept
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 3'd2, 32'(i * 4), 32'h0);
            chk("stream_trans", ahbl_trans, 2'b10);
            chk("stream_addr",  ahbl_addr, 32'(i * 4));
        end
        drain();
        for (int i = 0; i < 8; i++)
            if (i < got_rsp.size()) chk("stream_rdata_pattern", got_rsp[i], 32'(i * 4));
        scoreboard("stream");

        // Write then read of the same word
        send(1'b1, 3'd2, 32'h10, 32'h1010_1010);
        send(1'b0, 3'd2, 32'h10, 32'h0);
        drain();
        if (got_rsp.size() > 0) chk("wr_rd_data", got_rsp[0], 32'h1010_1010);
        scoreboard("wr_rd");

        // Byte / half lanes, size clamp and alignment
        send(1'b1, 3'd0, 32'h41, 32'hFFFF_43FF);
        send(1'b1, 3'd1, 32'h42, 32'h5152_FFFF);
        send(1'b0, 3'd2, 32'h40, 32'h0);
        drain();
        if (got_rsp.size() > 0) chk("lanes_data", got_rsp[0], 32'h5152_4340);
        if (got_ap.size() == 3) chk("lanes_sizes", {got_ap[0].size, got_ap[1].size, got_ap[2].size}, 9'o012);
        scoreboard("lanes");
        send(1'b1, 3'd1, 32'h43, 32'hAAAA_0000);
        chk("align_half_addr", ahbl_addr, 32'h42);
        send(1'b0, 3'd7, 32'h47, 32'h0);
        chk("clamp_size", ahbl_size, 3'd2);
        chk("clamp_addr", ahbl_addr, 32'h44);
        drain();
        scoreboard("align");

        // Wait states: read in DP, write in AP, HREADY low for 3 cycles
        send(1'b0, 3'd2, 32'h20, 32'h0);
        send(1'b1, 3'd2, 32'h24, 32'hCAFE_F00D);
        ahbl_ready = 1'b0;
        #1 s = snap_bus();
        w0 = wait_count;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_bus_stable", snap_bus(), s);
            chk("wait_no_rsp", rsp_valid, 1'b0);
        end
`ifdef AHBL_MST_STATS_EN
        chk("wait_count_3", wait_count, w0 + 16'd3);
`else
        chk("wait_count_tied", wait_count, 16'd0);
`endif
        ahbl_ready = 1'b1;
        drain();
        chk("wait_single_rsp", got_rsp.size(), 1);
        scoreboard("wait");

        // FIFO full with HREADY held low: 2 FIFO entries + AP + DP
        ahbl_ready = 1'b0;
        cnt = 0;
        req_valid = 1'b1; req_write = 1'b0; req_size = 3'd2;
        for (int i = 0; i < 10; i++) begin
            req_addr = 32'h80 + 32'(cnt * 4);
            #1 if (req_ready) cnt++;
            tick();
        end
        req_valid = 1'b0;
        chk("full_accepts", cnt, 4);
        #1 chk("full_req_ready", req_ready, 1'b0);

        // clken low for 5 cycles freezes everything even with HREADY high
        ahbl_ready = 1'b1; clken = 1'b0;
        #1 s = snap_all();
        chk("clken_req_ready", req_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("clken_frozen", snap_all(), s);
        end
        clken = 1'b1;
        drain();
        scoreboard("full");

        // Async reset mid-burst of 4 reads stuck behind HREADY low
        ahbl_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 3'd2, 32'hC0 + 32'(i * 4), 32'h0);
        #2 reset_n = 1'b0;
        #1 chk("areset_trans", ahbl_trans, 2'b00);
        chk("areset_rsp", rsp_valid, 1'b0);
        tick();
        reset_n = 1'b1; ahbl_ready = 1'b1;
        acc_q.delete(); got_ap.delete(); got_rsp.delete();
        #1 chk("areset_req_ready", req_ready, 1'b1);
        nrsp = 0; nbusy = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) nrsp++;
            if (ahbl_trans != 2'b00) nbusy++;
        end
        chk("areset_no_rsp", nrsp, 0);
        chk("areset_idle", nbusy, 0);

        // Randomised mix with random wait states
        rnd_wait = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 255)), $urandom());
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_wait = 1'b0; ahbl_ready = 1'b1;
        drain();
        scoreboard("rand");

`ifdef AHBL_MST_STATS_EN
        chk("xfer_count", xfer_count, 16'(n_xfer));
        chk("wait_count", wait_count, 16'(n_wait));
`else
        chk("xfer_count_tied", xfer_count, 16'd0);
        chk("wait_count_tied_end", wait_count, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
